int_hazard_ctrl: RTL

- Sequences the integer pipeline between decode/issue and writeback.
- Tracks destination registers of in-flight instructions in the EX and WB slots and drives the bypass mux selects for rs1/rs2.
- Stalls issue on load-use hazards and sequences retirement writes into the register file.
- Sits between decode and the ALU/LSU operand muxes in `core`, replacing ad-hoc compare logic.

---
 rtl/int_hazard_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/int_hazard_ctrl.sv
// Integer pipeline hazard controller: tracks EX/WB destinations, drives operand
// bypass selects, stalls issue on load-use and sequences regfile writeback.
`ifndef XLEN
`define XLEN 32
`endif

module int_hazard_ctrl #(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_rd_we,
    input  logic            issue_is_load,
    output logic [1:0]      fwd_sel_rs1,
    output logic [1:0]      fwd_sel_rs2,
    input  logic [XLEN-1:0] ex_result,
    input  logic            load_done,
    input  logic [XLEN-1:0] load_data,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [15:0]     stall_count
);

    logic            ex_valid_reg;
    logic [4:0]      ex_rd_reg;
    logic            ex_we_reg;
    logic            ex_is_load_reg;
    logic            ex_ready_reg;
    logic            wb_we_reg;
    logic [4:0]      wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic [15:0]     stall_count_reg;

    logic            ex_ready_now;
    logic            ex_can_adv;
    logic            accept;
    logic [4:0]      src_rs  [2];
    logic [1:0]      src_sel [2];
    logic            src_haz [2];

    // A waiting load becomes ready in the very cycle its data arrives.
    assign ex_ready_now = ex_ready_reg | (ex_is_load_reg & load_done);
    assign ex_can_adv   = !ex_valid_reg || ex_ready_now;

    assign src_rs[0] = issue_rs1;
    assign src_rs[1] = issue_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            always_comb begin
                src_sel[gi] = 2'd0;
                src_haz[gi] = 1'b0;
                if (src_rs[gi] == 5'd0) begin
                    src_sel[gi] = 2'd0;
                end else if (ex_valid_reg && ex_we_reg && ex_rd_reg == src_rs[gi]) begin
                    if (ex_ready_now) src_sel[gi] = 2'd1;
                    else              src_haz[gi] = 1'b1;
                end else if (wb_we_reg && wb_rd_reg == src_rs[gi]) begin
                    src_sel[gi] = 2'd2;
                end
            end
        end
    endgenerate

    assign issue_ready = rst || (!flush && !src_haz[0] && !src_haz[1] && ex_can_adv);
    assign fwd_sel_rs1 = rst ? 2'd0 : src_sel[0];
    assign fwd_sel_rs2 = rst ? 2'd0 : src_sel[1];
    assign accept      = issue_valid && issue_ready && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg    <= 1'b0;
            ex_rd_reg       <= 5'd0;
            ex_we_reg       <= 1'b0;
            ex_is_load_reg  <= 1'b0;
            ex_ready_reg    <= 1'b0;
            wb_we_reg       <= 1'b0;
            wb_rd_reg       <= 5'd0;
            wb_data_reg     <= '0;
            stall_count_reg <= 16'd0;
        end else begin
            if (ex_can_adv) begin
                // A flushed EX slot is killed rather than promoted to WB.
                wb_we_reg <= ex_valid_reg && !flush && ex_we_reg && (ex_rd_reg != 5'd0);
                if (ex_valid_reg && !flush) begin
                    wb_rd_reg   <= ex_rd_reg;
                    wb_data_reg <= ex_is_load_reg ? load_data : ex_result;
                end
                ex_valid_reg   <= accept;
                ex_rd_reg      <= issue_rd;
                ex_we_reg      <= issue_rd_we;
                ex_is_load_reg <= issue_is_load;
                ex_ready_reg   <= !issue_is_load;
            end else begin
                wb_we_reg <= 1'b0;
                if (flush)          ex_valid_reg <= 1'b0;
                else if (load_done) ex_ready_reg <= 1'b1;
            end

            if (issue_valid && !issue_ready && stall_count_reg != 16'hFFFF)
                stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    assign wb_we       = wb_we_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_data     = wb_data_reg;
    assign stall_count = stall_count_reg;

endmodule
